// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, working-mantissa layout,
// special constants and the sequential subtractor's state encoding.
package fpu_pkg;

  localparam int E_W   = 8;
  localparam int M_W   = 23;
  localparam int WM_W  = 27;
  localparam int EXP_W = 10;

  localparam logic [31:0]    QNAN    = 32'h7FC00000;
  localparam logic [E_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  // hidden bit, fraction, then three zero guard/round/sticky bits
  function automatic logic [WM_W-1:0] work_mant(input logic [31:0] x);
    return {(x[30:23] != '0), x[M_W-1:0], 3'b000};
  endfunction

  // field exponent 0 behaves as exponent 1 (denormals)
  function automatic logic signed [EXP_W-1:0] eff_exp(input logic [31:0] x);
    return (x[30:23] == '0) ? 10'sd1 : $signed({2'b00, x[30:23]});
  endfunction

endpackage

// File: rtl/fsub_round.sv
// Round-to-nearest-even, overflow detection and packing of the final
// result; owns the y/ovf output registers.
module fsub_round
  import fpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    load_norm,
  input  logic                    load_spec,
  input  logic [31:0]             spec_y,
  input  logic                    sign,
  input  logic signed [EXP_W-1:0] exp_in,
  input  logic [WM_W-1:0]         mant,
  output logic [31:0]             y,
  output logic                    ovf
);

  logic                    round_up;
  logic [24:0]             sum;
  logic [23:0]             mant_r;
  logic signed [EXP_W-1:0] exp_r;
  logic [31:0]             y_next;
  logic                    ovf_next;
  logic [31:0]             y_reg;
  logic                    ovf_reg;

  always_comb begin
    round_up = mant[2] & (mant[3] | mant[1] | mant[0]);
    sum      = {1'b0, mant[26:3]} + {24'd0, round_up};
    if (sum[24]) begin
      mant_r = sum[24:1];
      exp_r  = exp_in + 10'sd1;
    end else begin
      mant_r = sum[23:0];
      exp_r  = exp_in;
    end
    // a result without the hidden bit set is a denormal: field exponent 0
    if (exp_r >= 10'sd255) begin
      y_next   = {sign, EXP_MAX, {M_W{1'b0}}};
      ovf_next = 1'b1;
    end else begin
      y_next   = {sign, (mant_r[23] ? exp_r[7:0] : 8'd0), mant_r[M_W-1:0]};
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_reg   <= '0;
      ovf_reg <= 1'b0;
    end else if (load_spec) begin
      y_reg   <= spec_y;
      ovf_reg <= 1'b0;
    end else if (load_norm) begin
      y_reg   <= y_next;
      ovf_reg <= ovf_next;
    end
  end

  assign y   = y_reg;
  assign ovf = ovf_reg;

endmodule

// File: rtl/fsub_seq.sv
// Multi-cycle binary32 subtractor y = x1 - x2 with bit-serial alignment and
// normalisation, valid/ready handshakes on both sides.
module fsub_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  state_t state_reg, state_next;

  logic [WM_W-1:0]         ml_reg, ms_reg, mant_reg;
  logic                    sl_reg, ss_reg, sign_reg;
  logic signed [EXP_W-1:0] exp_reg;
  logic [4:0]              d_reg;

  // operand decode; x2 takes part with its sign inverted
  logic                    s1, s2;
  logic [E_W-1:0]          e1f, e2f;
  logic [M_W-1:0]          f1, f2;
  logic                    nan1, nan2, inf1, inf2, zero1, zero2;
  logic                    x1_large, accept;
  logic signed [EXP_W-1:0] e_lg, e_sm, e_diff;
  logic [4:0]              d_init;
  logic                    spec_hit;
  logic [31:0]             spec_y;

  assign s1       = x1[31];
  assign s2       = ~x2[31];
  assign e1f      = x1[30:23];
  assign e2f      = x2[30:23];
  assign f1       = x1[M_W-1:0];
  assign f2       = x2[M_W-1:0];
  assign nan1     = (e1f == EXP_MAX) && (f1 != '0);
  assign nan2     = (e2f == EXP_MAX) && (f2 != '0);
  assign inf1     = (e1f == EXP_MAX) && (f1 == '0);
  assign inf2     = (e2f == EXP_MAX) && (f2 == '0);
  assign zero1    = (e1f == '0) && (f1 == '0);
  assign zero2    = (e2f == '0) && (f2 == '0);
  assign x1_large = (e1f >= e2f);
  assign e_lg     = x1_large ? eff_exp(x1) : eff_exp(x2);
  assign e_sm     = x1_large ? eff_exp(x2) : eff_exp(x1);
  assign e_diff   = e_lg - e_sm;
  assign d_init   = (e_diff > 10'sd27) ? 5'd27 : e_diff[4:0];

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    spec_hit = 1'b1;
    spec_y   = '0;
    if (nan2)
      spec_y = {s2, EXP_MAX, 1'b1, f2[21:0]};
    else if (nan1)
      spec_y = {s1, EXP_MAX, 1'b1, f1[21:0]};
    else if (inf1 && inf2 && (s1 != s2))
      spec_y = QNAN;
    else if (inf1)
      spec_y = {s1, EXP_MAX, {M_W{1'b0}}};
    else if (inf2)
      spec_y = {s2, EXP_MAX, {M_W{1'b0}}};
    else if (zero1 && zero2)
      spec_y = {s1 & s2, 31'd0};
    else
      spec_hit = 1'b0;
  end

  // add/subtract on the aligned magnitudes
  logic [WM_W:0]   sum;
  logic            mag_ge;
  logic [WM_W-1:0] diff;
  logic            norm_shift;

  assign sum        = {1'b0, ml_reg} + {1'b0, ms_reg};
  assign mag_ge     = (ml_reg >= ms_reg);
  assign diff       = mag_ge ? (ml_reg - ms_reg) : (ms_reg - ml_reg);
  assign norm_shift = !mant_reg[26] && (mant_reg != '0) && (exp_reg > 10'sd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = spec_hit ? DONE : ALIGN;
      ALIGN:   if (d_reg == 5'd0) state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    if (!norm_shift) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ml_reg   <= '0;
      ms_reg   <= '0;
      mant_reg <= '0;
      sl_reg   <= 1'b0;
      ss_reg   <= 1'b0;
      sign_reg <= 1'b0;
      exp_reg  <= '0;
      d_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          ml_reg  <= x1_large ? work_mant(x1) : work_mant(x2);
          ms_reg  <= x1_large ? work_mant(x2) : work_mant(x1);
          sl_reg  <= x1_large ? s1 : s2;
          ss_reg  <= x1_large ? s2 : s1;
          exp_reg <= e_lg;
          d_reg   <= d_init;
        end
        ALIGN: if (d_reg != 5'd0) begin
          ms_reg <= {1'b0, ms_reg[26:2], ms_reg[1] | ms_reg[0]};
          d_reg  <= d_reg - 5'd1;
        end
        ADD: begin
          if (sl_reg == ss_reg) begin
            sign_reg <= sl_reg;
            if (sum[WM_W]) begin
              mant_reg <= {sum[27:2], sum[1] | sum[0]};
              exp_reg  <= exp_reg + 10'sd1;
            end else begin
              mant_reg <= sum[WM_W-1:0];
            end
          end else begin
            mant_reg <= diff;
            sign_reg <= (diff == '0) ? 1'b0 : (mag_ge ? sl_reg : ss_reg);
          end
        end
        NORM: if (norm_shift) begin
          mant_reg <= {mant_reg[25:0], 1'b0};
          exp_reg  <= exp_reg - 10'sd1;
        end
        default: ;
      endcase
    end
  end

  fsub_round u_round (
    .clk       (clk),
    .rstn      (rstn),
    .load_norm (state_reg == ROUND),
    .load_spec (accept && spec_hit),
    .spec_y    (spec_y),
    .sign      (sign_reg),
    .exp_in    (exp_reg),
    .mant      (mant_reg),
    .y         (y),
    .ovf       (ovf)
  );

endmodule
